timx_apb_cfg_master: RTL

//  APB3 initiator that programs the advanced timer's register file (ARR, CCRx, CCMRx, CCER, BDTR, EGR, CR1).

---
 rtl/timx_apb_cfg_master.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/timx_apb_cfg_master.sv
// APB3 initiator that drains a small command FIFO into the timer's register-file slave port.
// Optional ACCESS-phase watchdog enabled by defining TIMX_APB_TIMEOUT_EN.
module timx_apb_cfg_master #(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 32,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic          apb_clk,
  input  logic          apb_rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  output logic          timx_psel,
  output logic          timx_penable,
  output logic          timx_pwrite,
  output logic [AW-1:0] timx_paddr,
  output logic [DW-1:0] timx_pwdata,
  input  logic [DW-1:0] timx_prdata,
  input  logic          timx_pready,
  input  logic          timx_pslverr
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  cmd_t          fifo_mem [FIFO_DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          pop;
  logic          load;
  logic          fifo_empty;

  state_t        state;
  state_t        state_nxt;
  logic          psel_nxt;
  logic          penable_nxt;
  logic          pwrite_nxt;
  logic [AW-1:0] paddr_nxt;
  logic [DW-1:0] pwdata_nxt;
  logic          rsp_valid_nxt;
  logic [DW-1:0] rsp_rdata_nxt;
  logic          rsp_err_nxt;

`ifdef TIMX_APB_TIMEOUT_EN
  localparam int unsigned TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TW-1:0] tmo_cnt;
  logic [TW-1:0] tmo_cnt_nxt;
`else
  // TIMEOUT_CYC has no effect without the watchdog
  logic unused_tmo;
  assign unused_tmo = ^32'(TIMEOUT_CYC);
`endif

  assign push       = cmd_valid && cmd_ready;
  assign fifo_empty = (count == '0);
  assign head       = fifo_mem[rd_ptr];
  assign count_nxt  = count + CW'(push) - CW'(pop);

  // Command storage; contents are don't-care until written
  always_ff @(posedge apb_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    end
  end

  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count     <= count_nxt;
      cmd_ready <= (count_nxt != CW'(FIFO_DEPTH));
    end
  end

  // State and registered bus/response outputs
  always_ff @(posedge apb_clk or negedge apb_rst_n) begin
    if (!apb_rst_n) begin
      state        <= S_IDLE;
      timx_psel    <= 1'b0;
      timx_penable <= 1'b0;
      timx_pwrite  <= 1'b0;
      timx_paddr   <= '0;
      timx_pwdata  <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      busy         <= 1'b0;
`ifdef TIMX_APB_TIMEOUT_EN
      tmo_cnt      <= '0;
`endif
    end else begin
      state        <= state_nxt;
      timx_psel    <= psel_nxt;
      timx_penable <= penable_nxt;
      timx_pwrite  <= pwrite_nxt;
      timx_paddr   <= paddr_nxt;
      timx_pwdata  <= pwdata_nxt;
      rsp_valid    <= rsp_valid_nxt;
      rsp_rdata    <= rsp_rdata_nxt;
      rsp_err      <= rsp_err_nxt;
      busy         <= (count_nxt != '0) || (state_nxt != S_IDLE);
`ifdef TIMX_APB_TIMEOUT_EN
      tmo_cnt      <= tmo_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    pop           = 1'b0;
    load          = 1'b0;
    psel_nxt      = timx_psel;
    penable_nxt   = timx_penable;
    pwrite_nxt    = timx_pwrite;
    paddr_nxt     = timx_paddr;
    pwdata_nxt    = timx_pwdata;
    rsp_valid_nxt = 1'b0;
    rsp_rdata_nxt = rsp_rdata;
    rsp_err_nxt   = rsp_err;
`ifdef TIMX_APB_TIMEOUT_EN
    tmo_cnt_nxt   = tmo_cnt;
`endif

    case (state)
      S_IDLE: begin
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
        load        = !fifo_empty;
      end
      S_SETUP: begin
        penable_nxt = 1'b1;
        state_nxt   = S_ACCESS;
`ifdef TIMX_APB_TIMEOUT_EN
        tmo_cnt_nxt = '0;
`endif
      end
      S_ACCESS: begin
        if (timx_pready) begin
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = timx_pslverr;
          rsp_rdata_nxt = timx_pwrite ? '0 : timx_prdata;
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_nxt   = S_IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
          end
        end
`ifdef TIMX_APB_TIMEOUT_EN
        else if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) begin
          // Abort always passes through IDLE so the bus visibly deselects
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
          rsp_rdata_nxt = '0;
          state_nxt     = S_IDLE;
          psel_nxt      = 1'b0;
          penable_nxt   = 1'b0;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
        end
`endif
      end
      default: begin
        state_nxt   = S_IDLE;
        psel_nxt    = 1'b0;
        penable_nxt = 1'b0;
      end
    endcase

    // Pop the head straight into a SETUP phase
    if (load) begin
      pop         = 1'b1;
      state_nxt   = S_SETUP;
      psel_nxt    = 1'b1;
      penable_nxt = 1'b0;
      pwrite_nxt  = head.write;
      paddr_nxt   = head.addr;
      pwdata_nxt  = head.write ? head.wdata : '0;
    end
  end

endmodule
